midi_spi_tx: RTL and testbench
==============================

Name: midi_spi_tx

Overview:
- SPI transmit end of the note-event link into the synth's SPI receiver (sclk + mosi, mode 0, MSB first).
- Accepts one note event per valid/ready handshake and serialises it as a fixed 48-bit frame, followed by an idle gap.
- Used on the host/bridge side and as the stimulus driver in synth system benches.

Parameters:
- CLK_DIV, 4: i_clk cycles per sclk half-period (>=1).
- GAP_CYCLES, 16: idle i_clk cycles after each frame, sclk low (>=1).

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-low reset
- i_valid  in  1  note event present
- o_ready  out  1  block can accept an event
- i_note_status  in  1  1 = note on, 0 = note off
- i_voice_index  in  8  target voice
- i_tuning_code  in  32  phase-increment tuning word
- i_velocity  in  7  note velocity
- o_SPI_sclk  out  1  serial clock
- o_SPI_mosi  out  1  serial data
- o_busy  out  1  frame or gap in progress
- o_done  out  1  one-cycle pulse when frame and gap are complete

Behaviour:
- Frame: 48 bits, transmitted MSB first.
  - byte0 = {note_status, velocity[6:0]}
  - byte1 = voice_index
  - bytes2..5 = tuning_code[31:0], MSB byte first
- Handshake:
  - Accept occurs on a rising edge with i_valid && o_ready.
  - All inputs are latched into a 48-bit shift register that cycle; inputs are don't-care afterwards.
  - o_ready = (state==IDLE); o_busy = !o_ready.
  - i_valid while busy is ignored; it is not queued.
- States: IDLE, SCK_LO, SCK_HI, GAP.
  - IDLE -> SCK_LO on accept. mosi = frame[47] and sclk = 0 from the next cycle.
  - SCK_LO: hold CLK_DIV cycles, then -> SCK_HI with sclk = 1. Receiver samples on this rising edge; mosi is stable.
  - SCK_HI: hold CLK_DIV cycles. If bit counter < 47: shift left, increment counter, -> SCK_LO, with mosi changing in the same cycle sclk falls. Else -> GAP.
  - GAP: sclk = 0, mosi = 0 for GAP_CYCLES cycles, then -> IDLE with o_done = 1 for exactly that first IDLE cycle.
- Timing (accept cycle = 0):
  - Bit n's rising sclk edge is at cycle 1 + CLK_DIV + 2*CLK_DIV*n.
  - o_done is at cycle 1 + 96*CLK_DIV + GAP_CYCLES. Defaults give 401.
- Back-to-back operation: a new accept is permitted in the o_done cycle. Next frame starts the following cycle, so the minimum frame spacing is 2 + 96*CLK_DIV + GAP_CYCLES - 1 cycles.
- Counters:
  - Half-period counter is ceil(log2(CLK_DIV+1)) bits; gap counter is sized similarly.
  - Bit counter is 6 bits and never wraps past 47.
- Reset (asserted low, async, including mid-frame): state = IDLE, sclk = 0, mosi = 0, o_done = 0, shift register = 0, counters = 0. Resulting outputs: o_ready = 1, o_busy = 0.
  - A partially sent frame is abandoned. No partial-frame completion after release.
- Outputs are registered, except o_ready/o_busy, which decode from the state register.

Optional Feature:
- Macro: MIDI_SPI_TX_CS_EN.
- Defined: adds output o_SPI_cs_n (1 bit).
  - Reset value 1.
  - Goes low in the same cycle as the first SCK_LO.
  - Returns high on entry to GAP and stays high in GAP and IDLE.
- Undefined: port and logic are absent. Framing relies on the receiver's bit count plus the idle gap.

Test Plan:
- Reset release, then note on, voice 0x03, tuning 0x12345678, velocity 0x64 -> captured mosi bits on sclk rising edges equal 0xE4_03_12_34_56_78. Exactly 48 rising edges. o_done at cycle 401.
- Note off, voice 0xFF, tuning 0xFFFFFFFF, velocity 0 -> frame 0x00_FF_FFFFFFFF. sclk high/low half-periods each exactly 4 cycles. mosi constant across every sclk high.
- i_valid held high for 3 consecutive events -> accepts only in IDLE/o_done cycles. Three frames are sent with 16-cycle gaps, and inputs changed mid-frame do not corrupt the frame.
- Assert i_reset low at bit 20 -> sclk = 0, mosi = 0, o_ready = 1 immediately (async). After release, a new event sends a complete correct 48-bit frame.
- CLK_DIV=1, GAP_CYCLES=1 -> o_done at cycle 98; frame bits are correct.
- With MIDI_SPI_TX_CS_EN -> cs_n low for exactly 96*CLK_DIV cycles per frame and high in gap/idle; reset value 1.

Source files
------------

// File: rtl/midi_spi_tx.sv
// midi_spi_tx - SPI (mode 0, MSB first) transmitter for note events.
//
// One event per valid/ready handshake is latched into a 48-bit frame:
//   {note_status, velocity[6:0], voice_index[7:0], tuning_code[31:0]}
// and shifted out on sclk/mosi, followed by an idle gap of GAP_CYCLES.
//
// Parameters:
//   CLK_DIV    - i_clk cycles per sclk half-period (>=1)
//   GAP_CYCLES - idle cycles after each frame, sclk low (>=1)
//
// Ports:
//   i_clk, i_reset (async, active low)
//   i_valid / o_ready          - event handshake (o_ready = IDLE)
//   i_note_status, i_voice_index, i_tuning_code, i_velocity - event fields
//   o_SPI_sclk, o_SPI_mosi     - serial link
//   o_SPI_cs_n                 - only when MIDI_SPI_TX_CS_EN is defined
//   o_busy                     - frame or gap in progress
//   o_done                     - 1-cycle pulse in the first IDLE cycle after the gap
//
// Optional: define MIDI_SPI_TX_CS_EN to add the active-low chip select.
module midi_spi_tx #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_note_status,
  input  logic [7:0]  i_voice_index,
  input  logic [31:0] i_tuning_code,
  input  logic [6:0]  i_velocity,
  output logic        o_SPI_sclk,
  output logic        o_SPI_mosi,
`ifdef MIDI_SPI_TX_CS_EN
  output logic        o_SPI_cs_n,
`endif
  output logic        o_busy,
  output logic        o_done
);

  localparam int HW = $clog2(CLK_DIV + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SCK_LO, SCK_HI, GAP} state_t;

  state_t        state, state_nx;
  logic [HW-1:0] hcnt;
  logic [GW-1:0] gcnt;
  logic [5:0]    bcnt;
  logic [47:0]   shreg;
  logic [47:0]   frame_in;
  logic          accept, half_end, gap_end, last_bit;

  assign frame_in = {i_note_status, i_velocity, i_voice_index, i_tuning_code};
  assign accept   = i_valid && (state == IDLE);
  assign half_end = (hcnt == HW'(CLK_DIV - 1));
  assign gap_end  = (gcnt == GW'(GAP_CYCLES - 1));
  assign last_bit = (bcnt == 6'd47);

  assign o_ready = (state == IDLE);
  assign o_busy  = !o_ready;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)   state_nx = SCK_LO;
      SCK_LO:  if (half_end) state_nx = SCK_HI;
      SCK_HI:  if (half_end) state_nx = last_bit ? GAP : SCK_LO;
      GAP:     if (gap_end)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      hcnt       <= '0;
      gcnt       <= '0;
      bcnt       <= '0;
      shreg      <= '0;
      o_SPI_sclk <= 1'b0;
      o_SPI_mosi <= 1'b0;
      o_done     <= 1'b0;
`ifdef MIDI_SPI_TX_CS_EN
      o_SPI_cs_n <= 1'b1;
`endif
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          // mosi is presented straight from the inputs so bit 47 is valid
          // in the first SCK_LO cycle.
          shreg      <= frame_in;
          o_SPI_mosi <= frame_in[47];
          o_SPI_sclk <= 1'b0;
          hcnt       <= '0;
          bcnt       <= '0;
`ifdef MIDI_SPI_TX_CS_EN
          o_SPI_cs_n <= 1'b0;
`endif
        end
        SCK_LO: begin
          if (half_end) begin
            hcnt       <= '0;
            o_SPI_sclk <= 1'b1;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        SCK_HI: begin
          if (half_end) begin
            hcnt       <= '0;
            o_SPI_sclk <= 1'b0;
            if (last_bit) begin
              o_SPI_mosi <= 1'b0;
              gcnt       <= '0;
`ifdef MIDI_SPI_TX_CS_EN
              o_SPI_cs_n <= 1'b1;
`endif
            end else begin
              // Rotate rather than zero-fill: bits past the frame are never
              // sent, and mosi changes on the same edge sclk falls.
              shreg      <= {shreg[46:0], shreg[47]};
              o_SPI_mosi <= shreg[46];
              bcnt       <= bcnt + 6'd1;
            end
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_end) begin
            gcnt   <= '0;
            o_done <= 1'b1;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_midi_spi_tx.sv
// Directed bench for midi_spi_tx: default instance (CLK_DIV=4, GAP=16) and
// a fast instance (CLK_DIV=1, GAP=1), selected one at a time via sel.
module tb_midi_spi_tx;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        valid = 1'b0;
  logic        st    = 1'b0;
  logic [7:0]  vi    = '0;
  logic [31:0] tc    = '0;
  logic [6:0]  vel   = '0;
  bit          sel   = 1'b0;

  logic a_ready, a_sclk, a_mosi, a_busy, a_done;
  logic b_ready, b_sclk, b_mosi, b_busy, b_done;
  logic a_valid, b_valid;
  assign a_valid = valid & ~sel;
  assign b_valid = valid & sel;

`ifdef MIDI_SPI_TX_CS_EN
  logic a_cs, b_cs;
`endif

  midi_spi_tx dut_a (
    .i_clk(clk), .i_reset(rst_n), .i_valid(a_valid), .o_ready(a_ready),
    .i_note_status(st), .i_voice_index(vi), .i_tuning_code(tc), .i_velocity(vel),
    .o_SPI_sclk(a_sclk), .o_SPI_mosi(a_mosi),
`ifdef MIDI_SPI_TX_CS_EN
    .o_SPI_cs_n(a_cs),
`endif
    .o_busy(a_busy), .o_done(a_done)
  );

  midi_spi_tx #(.CLK_DIV(1), .GAP_CYCLES(1)) dut_b (
    .i_clk(clk), .i_reset(rst_n), .i_valid(b_valid), .o_ready(b_ready),
    .i_note_status(st), .i_voice_index(vi), .i_tuning_code(tc), .i_velocity(vel),
    .o_SPI_sclk(b_sclk), .o_SPI_mosi(b_mosi),
`ifdef MIDI_SPI_TX_CS_EN
    .o_SPI_cs_n(b_cs),
`endif
    .o_busy(b_busy), .o_done(b_done)
  );

  logic m_ready, m_sclk, m_mosi, m_busy, m_done;
  assign m_ready = sel ? b_ready : a_ready;
  assign m_sclk  = sel ? b_sclk  : a_sclk;
  assign m_mosi  = sel ? b_mosi  : a_mosi;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_done  = sel ? b_done  : a_done;
`ifdef MIDI_SPI_TX_CS_EN
  logic m_cs;
  assign m_cs = sel ? b_cs : a_cs;
`endif

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sends one event starting at the current negedge (cycle 0 = accept cycle)
  // and follows it to o_done, capturing mosi on each sclk rise. With
  // abort_at >= 0, reset is asserted right after that bit has been sampled.
  task automatic xfer(input string tag, input logic s, input logic [7:0] v,
                      input logic [31:0] t, input logic [6:0] ve, input bit keep,
                      input int abort_at, input logic [47:0] expf,
                      output bit aborted);
    int cd, gp, lo, hi, nrise, nacc, t0, done_at, cs_low;
    logic prev, bitv;
    logic [47:0] cap;
    bit hp_ok;
    cd = sel ? 1 : 4;
    gp = sel ? 1 : 16;
    cap = '0; nrise = 0; done_at = -1; hp_ok = 1'b1; aborted = 1'b0;
    cs_low = 0; lo = 0; hi = 0; prev = 1'b0; bitv = 1'b0;
    st = s; vi = v; tc = t; vel = ve; valid = 1'b1;
    t0 = cyc;
    nacc = m_ready ? 1 : 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!keep) valid = 1'b0;
      if (k == 0) chk({tag, "_busy"}, {63'd0, m_busy}, 64'd1);
      if (m_sclk) begin
        if (!prev) begin
          if (lo != cd) hp_ok = 1'b0;
          if (cyc - t0 != 1 + cd + 2 * cd * nrise) hp_ok = 1'b0;
          bitv = m_mosi;
          cap = {cap[46:0], m_mosi};
          nrise++;
          hi = 0;
        end
        hi++;
        if (m_mosi !== bitv) hp_ok = 1'b0;
      end else begin
        if (prev) begin
          if (hi != cd) hp_ok = 1'b0;
          lo = 0;
        end
        lo++;
      end
      prev = m_sclk;
`ifdef MIDI_SPI_TX_CS_EN
      if (m_cs === 1'b0) cs_low++;
`endif
      // Scribble over the inputs mid-frame; the latched frame must not care.
      if (nrise >= 1) begin
        st = 1'($urandom()); vi = 8'($urandom()); tc = $urandom(); vel = 7'($urandom());
      end
      if (abort_at >= 0 && nrise == abort_at + 1) begin
        rst_n = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (m_done) begin
        done_at = cyc - t0;
        break;
      end
      if (valid && m_ready) nacc++;
    end
    if (!aborted) begin
      chk({tag, "_frame"}, {16'd0, cap}, {16'd0, expf});
      chk({tag, "_rises"}, 64'(nrise), 64'd48);
      chk({tag, "_done_at"}, 64'(done_at), 64'(1 + 96 * cd + gp));
      chk({tag, "_timing"}, {63'd0, hp_ok}, 64'd1);
      chk({tag, "_accepts"}, 64'(nacc), 64'd1);
`ifdef MIDI_SPI_TX_CS_EN
      chk({tag, "_cs_low"}, 64'(cs_low), 64'(96 * cd));
`endif
    end
  endtask

  initial begin
    bit ab;
    bit quiet;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {63'd0, a_ready}, 64'd1);
    chk("rst_busy",  {63'd0, a_busy},  64'd0);
    chk("rst_sclk",  {63'd0, a_sclk},  64'd0);
    chk("rst_mosi",  {63'd0, a_mosi},  64'd0);
    chk("rst_done",  {63'd0, a_done},  64'd0);
`ifdef MIDI_SPI_TX_CS_EN
    chk("rst_cs", {63'd0, a_cs}, 64'd1);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Basic note on, then an all-ones/zero pattern.
    xfer("t1", 1'b1, 8'h03, 32'h12345678, 7'h64, 1'b0, -1, 48'hE4_03_12345678, ab);
    repeat (5) @(negedge clk);
    xfer("t2", 1'b0, 8'hFF, 32'hFFFFFFFF, 7'h00, 1'b0, -1, 48'h00_FF_FFFFFFFF, ab);
    repeat (3) @(negedge clk);

    // i_valid held high across three back-to-back events.
    xfer("t3a", 1'b1, 8'h10, 32'hA5A50F0F, 7'h7F, 1'b1, -1, 48'hFF_10_A5A50F0F, ab);
    xfer("t3b", 1'b0, 8'h5A, 32'h00000001, 7'h01, 1'b1, -1, 48'h01_5A_00000001, ab);
    xfer("t3c", 1'b1, 8'h80, 32'h80000000, 7'h00, 1'b1, -1, 48'h80_80_80000000, ab);
    valid = 1'b0;
    repeat (3) @(negedge clk);

    // Reset mid-frame after bit 20.
    xfer("t4", 1'b1, 8'hAA, 32'h0F0F0F0F, 7'h11, 1'b0, 20, 48'h0, ab);
    chk("t4_aborted", {63'd0, ab}, 64'd1);
    #1;
    chk("t4_sclk",  {63'd0, a_sclk},  64'd0);
    chk("t4_mosi",  {63'd0, a_mosi},  64'd0);
    chk("t4_ready", {63'd0, a_ready}, 64'd1);
    chk("t4_busy",  {63'd0, a_busy},  64'd0);
`ifdef MIDI_SPI_TX_CS_EN
    chk("t4_cs", {63'd0, a_cs}, 64'd1);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (a_sclk || a_done || a_busy) quiet = 1'b0;
    end
    chk("t4_no_resume", {63'd0, quiet}, 64'd1);
    xfer("t5", 1'b1, 8'h42, 32'hDEADBEEF, 7'h33, 1'b0, -1, 48'hB3_42_DEADBEEF, ab);
    repeat (3) @(negedge clk);

    // Fast instance: CLK_DIV=1, GAP_CYCLES=1.
    sel = 1'b1;
    @(negedge clk);
    xfer("t6", 1'b1, 8'h07, 32'hCAFEF00D, 7'h55, 1'b0, -1, 48'hD5_07_CAFEF00D, ab);
    xfer("t7", 1'b0, 8'h00, 32'h00000000, 7'h7F, 1'b0, -1, 48'h7F_00_00000000, ab);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
